// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with byte/half/word access, alignment/range
// faults, a configurable wait-state handshake and a zeroing sweep after reset.
module data_memory_sized #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        ack,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        range_err
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned WCW = 4;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            lat_we_q, lat_we_d;
  logic [1:0]      lat_size_q, lat_size_d;
  logic            lat_sgn_q, lat_sgn_d;
  logic [31:0]     lat_addr_q, lat_addr_d;
  logic [31:0]     lat_wdata_q, lat_wdata_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            rng_q, rng_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // With zero wait states the access commits on the accepting edge, so use live inputs in IDLE.
  logic            acc_we_c, acc_sgn_c;
  logic [1:0]      acc_size_c, acc_off_c;
  logic [31:0]     acc_addr_c, acc_wdata_c;
  logic [AW-1:0]   acc_idx_c;
  logic [31:0]     rd_word_c, merged_c, load_c;
  logic [7:0]      lane8_c;
  logic [15:0]     lane16_c;
  logic            mis_c, rng_c, commit_c;
  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [31:0]     mem_wdata_c;

  always_comb begin
    acc_we_c    = (state_q == S_IDLE) ? we         : lat_we_q;
    acc_size_c  = (state_q == S_IDLE) ? size       : lat_size_q;
    acc_sgn_c   = (state_q == S_IDLE) ? signed_ld  : lat_sgn_q;
    acc_addr_c  = (state_q == S_IDLE) ? addr       : lat_addr_q;
    acc_wdata_c = (state_q == S_IDLE) ? write_data : lat_wdata_q;
    acc_off_c   = acc_addr_c[1:0];
    acc_idx_c   = acc_addr_c[AW+1:2];
    rd_word_c   = mem_q[acc_idx_c];
    mis_c = (acc_size_c == 2'b11) ||
            ((acc_size_c == 2'b01) && acc_off_c[0]) ||
            ((acc_size_c == 2'b10) && (acc_off_c != 2'b00));
    rng_c = ((acc_addr_c >> (AW + 2)) != 32'd0);
  end

  // Lane select (offset 0 is the most significant byte) and store merge.
  always_comb begin
    case (acc_off_c)
      2'd0:    lane8_c = rd_word_c[31:24];
      2'd1:    lane8_c = rd_word_c[23:16];
      2'd2:    lane8_c = rd_word_c[15:8];
      default: lane8_c = rd_word_c[7:0];
    endcase
    lane16_c = acc_off_c[1] ? rd_word_c[15:0] : rd_word_c[31:16];

    case (acc_size_c)
      2'b00:   load_c = {{24{acc_sgn_c & lane8_c[7]}}, lane8_c};
      2'b01:   load_c = {{16{acc_sgn_c & lane16_c[15]}}, lane16_c};
      default: load_c = rd_word_c;
    endcase

    merged_c = rd_word_c;
    case (acc_size_c)
      2'b00: begin
        case (acc_off_c)
          2'd0:    merged_c[31:24] = acc_wdata_c[7:0];
          2'd1:    merged_c[23:16] = acc_wdata_c[7:0];
          2'd2:    merged_c[15:8]  = acc_wdata_c[7:0];
          default: merged_c[7:0]   = acc_wdata_c[7:0];
        endcase
      end
      2'b01: begin
        if (acc_off_c[1]) merged_c[15:0]  = acc_wdata_c[15:0];
        else              merged_c[31:16] = acc_wdata_c[15:0];
      end
      default: merged_c = acc_wdata_c;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wait_d      = wait_q;
    lat_we_d    = lat_we_q;
    lat_size_d  = lat_size_q;
    lat_sgn_d   = lat_sgn_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    mis_d       = 1'b0;
    rng_d       = 1'b0;
    commit_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = acc_idx_c;
    mem_wdata_c = merged_c;

    case (state_q)
      S_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = sweep_q;
        mem_wdata_c = 32'd0;
        if (sweep_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = S_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (req) begin
          lat_we_d    = we;
          lat_size_d  = size;
          lat_sgn_d   = signed_ld;
          lat_addr_d  = addr;
          lat_wdata_d = write_data;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wait_d  = WCW'(WAIT_STATES - 1);
          end else begin
            commit_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) commit_c = 1'b1;
        else              wait_d   = wait_q - WCW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // The edge entering RESP performs the array access and registers the response.
    if (commit_c) begin
      state_d = S_RESP;
      ack_d   = 1'b1;
      mis_d   = mis_c;
      rng_d   = rng_c;
      if (mis_c || rng_c) rdata_d  = 32'd0;
      else if (acc_we_c)  mem_we_c = 1'b1;
      else                rdata_d  = load_c;
    end

    busy_d = (state_d == S_INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      wait_q      <= '0;
      lat_we_q    <= 1'b0;
      lat_size_q  <= 2'b00;
      lat_sgn_q   <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mis_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wait_q      <= wait_d;
      lat_we_q    <= lat_we_d;
      lat_size_q  <= lat_size_d;
      lat_sgn_q   <= lat_sgn_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      rng_q       <= rng_d;
    end
  end

  // Array has no reset; the sweep clears it, and reset blocks any pending commit.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign busy       = busy_q;
  assign ack        = ack_q;
  assign read_data  = rdata_q;
  assign misaligned = mis_q;
  assign range_err  = rng_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench: DUT a (256 words, 2 wait states) and DUT b (16 words, 0 wait states).
module tb_data_memory_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, we_a, sgn_a, busy_a, ack_a, mis_a, rng_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic        rst_b, req_b, we_b, sgn_b, busy_b, ack_b, mis_b, rng_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wd_b, rd_b;

  int checks = 0;
  int errors = 0;

  data_memory_sized #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .we(we_a), .size(size_a), .signed_ld(sgn_a),
    .addr(addr_a), .write_data(wd_a), .busy(busy_a), .ack(ack_a), .read_data(rd_a),
    .misaligned(mis_a), .range_err(rng_a));

  data_memory_sized #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .we(we_b), .size(size_b), .signed_ld(sgn_b),
    .addr(addr_b), .write_data(wd_b), .busy(busy_b), .ack(ack_b), .read_data(rd_b),
    .misaligned(mis_b), .range_err(rng_b));

  // One access; lat = cycles from sampling edge to ack seen (0 on timeout); *_n sampled one cycle later.
  task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic m, output logic r, output int lat,
                        output logic ack_n, output logic m_n, output logic r_n);
    lat = 0;
    rd = 32'hx; m = 1'bx; r = 1'bx;
    if (!sel) begin req_a = 1; we_a = w; size_a = sz; sgn_a = sg; addr_a = a; wd_a = wd; end
    else      begin req_b = 1; we_b = w; size_b = sz; sgn_b = sg; addr_b = a; wd_b = wd; end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1) begin req_a = 0; req_b = 0; end
      if ((!sel && ack_a) || (sel && ack_b)) begin
        lat = i;
        rd = sel ? rd_b : rd_a; m = sel ? mis_b : mis_a; r = sel ? rng_b : rng_a;
        break;
      end
    end
    @(posedge clk); @(negedge clk);
    ack_n = sel ? ack_b : ack_a; m_n = sel ? mis_b : mis_a; r_n = sel ? rng_b : rng_a;
  endtask

  logic [31:0] rd;
  logic m, r, an, mn, rn;
  int lat;

  task automatic test_reset;
    int n;
    rst_a = 1; rst_b = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy_a); end
    checks++; if ({ack_a, mis_a, rng_a} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {ack_a, mis_a, rng_a}); end
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 00000000", rd_a); end
    rst_a = 0; rst_b = 0;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); @(negedge clk);
      if (!busy_a) begin n = i; break; end
    end
    checks++; if (n !== 256) begin errors++; $display("FAIL sweep_a_len got %0d exp 256", n); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL sweep_b_done got %b exp 0", busy_b); end
    access(0, 0, 2'b10, 0, 32'h3FC, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw_3fc got %h exp 00000000", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lat_ws2 got %0d exp 3", lat); end
    checks++; if ({m, r, an} !== 3'b000) begin errors++; $display("FAIL lw_3fc_flags got %b exp 000", {m, r, an}); end
  endtask

  task automatic test_byte_store;
    access(0, 1, 2'b10, 0, 32'h4, 32'h11223344, rd, m, r, lat, an, mn, rn);
    access(0, 1, 2'b00, 0, 32'h5, 32'h123456AB, rd, m, r, lat, an, mn, rn);
    access(0, 0, 2'b10, 0, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL sb_merge got %h exp 11AB3344", rd); end
    access(0, 0, 2'b00, 1, 32'h5, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL ldsb_5 got %h exp FFFFFFAB", rd); end
    access(0, 0, 2'b00, 0, 32'h5, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL ldub_5 got %h exp 000000AB", rd); end
    access(0, 0, 2'b00, 1, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL ldsb_4 got %h exp 00000011", rd); end
  endtask

  task automatic test_half_store;
    access(0, 1, 2'b01, 1, 32'h6, 32'hCAFE8001, rd, m, r, lat, an, mn, rn);
    access(0, 0, 2'b01, 0, 32'h6, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lduh_6 got %h exp 00008001", rd); end
    access(0, 0, 2'b01, 1, 32'h6, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL ldsh_6 got %h exp FFFF8001", rd); end
    access(0, 0, 2'b10, 0, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h11AB8001) begin errors++; $display("FAIL sh_merge got %h exp 11AB8001", rd); end
    access(0, 0, 2'b01, 1, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h000011AB) begin errors++; $display("FAIL ldsh_4 got %h exp 000011AB", rd); end
    access(0, 0, 2'b00, 0, 32'h7, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL ldub_7 got %h exp 00000001", rd); end
    // A clean store must leave read_data at the last load value.
    access(0, 1, 2'b10, 0, 32'h10, 32'h00000005, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL store_holds_rdata got %h exp 00000001", rd); end
    access(0, 0, 2'b10, 0, 32'h10, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h00000005) begin errors++; $display("FAIL raw_10 got %h exp 00000005", rd); end
  endtask

  task automatic test_misaligned;
    access(0, 0, 2'b01, 0, 32'h3, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL lh_3 got m%b r%b %h exp m1 r0 00000000", m, r, rd); end
    checks++; if ({an, mn} !== 2'b00) begin errors++; $display("FAIL mis_clear got ack%b m%b exp 00", an, mn); end
    access(0, 1, 2'b10, 0, 32'h2, 32'hDEADBEEF, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL sw_2 got m%b r%b %h exp m1 r0 00000000", m, r, rd); end
    access(0, 0, 2'b11, 0, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL size11 got m%b r%b %h exp m1 r0 00000000", m, r, rd); end
    access(0, 0, 2'b10, 0, 32'h0, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_nowrite_0 got %h exp 00000000", rd); end
    access(0, 0, 2'b10, 0, 32'h4, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h11AB8001) begin errors++; $display("FAIL mis_keep_4 got %h exp 11AB8001", rd); end
  endtask

  task automatic test_range;
    access(0, 1, 2'b10, 0, 32'h400, 32'h55555555, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r, rd} !== {2'b01, 32'h0}) begin errors++; $display("FAIL sw_400 got m%b r%b %h exp m0 r1 00000000", m, r, rd); end
    checks++; if (rn !== 1'b0) begin errors++; $display("FAIL rng_clear got %b exp 0", rn); end
    access(0, 0, 2'b10, 0, 32'h0, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rng_nowrite_0 got %h exp 00000000", rd); end
    access(0, 0, 2'b10, 0, 32'h80000000, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r} !== 2'b01) begin errors++; $display("FAIL lw_hi_nowrap got m%b r%b exp m0 r1", m, r); end
    access(0, 0, 2'b01, 0, 32'h401, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r} !== 2'b11) begin errors++; $display("FAIL both_faults got m%b r%b exp m1 r1", m, r); end
  endtask

  task automatic test_back_to_back;
    int first, second, n;
    first = 0; second = 0; n = 0;
    req_a = 1; we_a = 0; size_a = 2'b10; sgn_a = 0; addr_a = 32'h4; wd_a = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack_a) begin
        n++;
        if (n == 1) first = i;
        else begin second = i; req_a = 0; break; end
      end
    end
    req_a = 0;
    checks++; if (second - first !== 4) begin errors++; $display("FAIL b2b_period got %0d exp 4", second - first); end
    checks++; if (rd_a !== 32'h11AB8001) begin errors++; $display("FAIL b2b_data got %h exp 11AB8001", rd_a); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_rst_in_wait;
    int n, acks;
    req_a = 1; we_a = 1; size_a = 2'b10; sgn_a = 0; addr_a = 32'h8; wd_a = 32'h7;
    @(posedge clk); @(negedge clk);
    req_a = 0; rst_a = 1;
    @(posedge clk); @(negedge clk);
    checks++; if ({busy_a, ack_a} !== 2'b10) begin errors++; $display("FAIL rst_wait got busy%b ack%b exp 10", busy_a, ack_a); end
    acks = 0;
    @(posedge clk); @(negedge clk);
    acks += int'(ack_a);
    rst_a = 0;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); @(negedge clk);
      acks += int'(ack_a);
      if (!busy_a) begin n = i; break; end
    end
    checks++; if (n !== 256) begin errors++; $display("FAIL resweep_len got %0d exp 256", n); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL dropped_ack got %0d exp 0", acks); end
    access(0, 0, 2'b10, 0, 32'h8, 0, rd, m, r, lat, an, mn, rn);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dropped_store got %h exp 00000000", rd); end
  endtask

  task automatic test_zero_wait;
    access(1, 1, 2'b10, 0, 32'h8, 32'h7, rd, m, r, lat, an, mn, rn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lat_ws0_store got %0d exp 1", lat); end
    access(1, 0, 2'b10, 0, 32'h8, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({lat, rd} !== {32'd1, 32'h7}) begin errors++; $display("FAIL ws0_load got lat%0d %h exp lat1 00000007", lat, rd); end
    access(1, 0, 2'b10, 0, 32'h3C, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r, rd} !== {2'b00, 32'h0}) begin errors++; $display("FAIL ws0_top got m%b r%b %h exp m0 r0 00000000", m, r, rd); end
    access(1, 0, 2'b10, 0, 32'h40, 0, rd, m, r, lat, an, mn, rn);
    checks++; if ({m, r} !== 2'b01) begin errors++; $display("FAIL ws0_range got m%b r%b exp m0 r1", m, r); end
  endtask

  initial begin
    {req_a, we_a, sgn_a, size_a, addr_a, wd_a} = '0;
    {req_b, we_b, sgn_b, size_b, addr_b, wd_b} = '0;
    rst_a = 1; rst_b = 1;
    @(negedge clk);
    test_reset();
    test_byte_store();
    test_half_store();
    test_misaligned();
    test_range();
    test_back_to_back();
    test_rst_in_wait();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
